conv_accumulator: RTL

CONV_ACCUMULATOR -- requirements
Module: conv_accumulator

---
 rtl/conv_pkg.sv | 24 ++
 rtl/lead_one_detector.sv | 20 ++
 rtl/conv_accumulator.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/conv_pkg.sv
// Shared definitions for the convolution accumulator: FSM states, FP16 constants, tap count.
package conv_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StAcc,
        StNorm,
        StOut
    } state_e;

    localparam int unsigned Fp16Bias = 15;
    localparam int unsigned NumTaps  = 9;

    // Wide enough that nine full-scale products cannot overflow.
    function automatic int unsigned acc_width(input int unsigned mant_size);
        return 2 * mant_size + 5;
    endfunction

    localparam int unsigned AccWidth = acc_width(10);

    localparam logic [4:0] SatExp  = 5'h1E;
    localparam logic [9:0] SatMant = 10'h3FF;

endpackage

// File: rtl/lead_one_detector.sv
// Combinational leading-one detector: position of the highest set bit plus an all-zero flag.
module lead_one_detector #(
    parameter int unsigned Width = 25,
    parameter int unsigned PosW  = $clog2(Width)
) (
    input  logic [Width-1:0] data,
    output logic [PosW-1:0]  pos,
    output logic             zero
);

    always_comb begin
        pos = '0;
        for (int i = 0; i < Width; i++) begin
            if (data[i]) pos = PosW'(i);
        end
    end

    assign zero = ~|data;

endmodule

// File: rtl/conv_accumulator.sv
// Sums nine sign-magnitude products (one tap per cycle) and normalises the total to FP16.
// Define CONV_ACC_ROUND_NEAREST_EN for round-to-nearest-even; the default build truncates.
module conv_accumulator
    import conv_pkg::*;
#(
    parameter int unsigned EXP_SIZE    = 5,
    parameter int unsigned MANT_SIZE   = 10,
    parameter int unsigned KERNEL_SIZE = 3
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [2*MANT_SIZE:0]        sign_mant_p1,
    input  logic [2*MANT_SIZE:0]        sign_mant_p2,
    input  logic [2*MANT_SIZE:0]        sign_mant_p3,
    input  logic [2*MANT_SIZE:0]        sign_mant_p4,
    input  logic [2*MANT_SIZE:0]        sign_mant_p5,
    input  logic [2*MANT_SIZE:0]        sign_mant_p6,
    input  logic [2*MANT_SIZE:0]        sign_mant_p7,
    input  logic [2*MANT_SIZE:0]        sign_mant_p8,
    input  logic [2*MANT_SIZE:0]        sign_mant_p9,
    input  logic [EXP_SIZE:0]           exp_p1,
    input  logic [EXP_SIZE:0]           exp_p2,
    input  logic [EXP_SIZE:0]           exp_p3,
    input  logic [EXP_SIZE:0]           exp_p4,
    input  logic [EXP_SIZE:0]           exp_p5,
    input  logic [EXP_SIZE:0]           exp_p6,
    input  logic [EXP_SIZE:0]           exp_p7,
    input  logic [EXP_SIZE:0]           exp_p8,
    input  logic [EXP_SIZE:0]           exp_p9,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [EXP_SIZE+MANT_SIZE:0] result
);

    localparam int unsigned MagW   = 2 * MANT_SIZE;
    localparam int unsigned AccW   = acc_width(MANT_SIZE);
    localparam int unsigned PosW   = $clog2(AccW);
    localparam int unsigned BinPt  = MagW - 2;
    localparam int unsigned ExpInW = EXP_SIZE + 1;
    localparam int unsigned ExpW   = ExpInW + 4;
    localparam int unsigned Taps   = KERNEL_SIZE * KERNEL_SIZE;
    localparam int unsigned CntW   = $clog2(NumTaps + 1);
    localparam int unsigned ExpMax = (1 << EXP_SIZE) - 1;
    localparam int unsigned ResW   = 1 + EXP_SIZE + MANT_SIZE;

    state_e                   state_q, state_d;
    logic signed [AccW-1:0]   acc_q, acc_d;
    logic [CntW-1:0]          cnt_q, cnt_d;
    logic                     phase_q, phase_d;
    logic [ResW-1:0]          result_q, result_d;
    logic                     load, norm_load, res_load;

    logic [MagW:0]            in_sm  [NumTaps];
    logic [ExpInW-1:0]        in_exp [NumTaps];
    logic [MagW:0]            sm_q   [NumTaps];
    logic [ExpInW-1:0]        exp_q  [NumTaps];
    logic [ExpInW-1:0]        emax_in, emax_q;

    assign in_sm  = '{sign_mant_p1, sign_mant_p2, sign_mant_p3, sign_mant_p4, sign_mant_p5,
                      sign_mant_p6, sign_mant_p7, sign_mant_p8, sign_mant_p9};
    assign in_exp = '{exp_p1, exp_p2, exp_p3, exp_p4, exp_p5, exp_p6, exp_p7, exp_p8, exp_p9};

    always_comb begin
        emax_in = '0;
        for (int i = 0; i < NumTaps; i++) begin
            if (in_exp[i] > emax_in) emax_in = in_exp[i];
        end
    end

    // Align the current tap to emax; bits shifted out are dropped.
    logic [ExpInW-1:0]      shamt;
    logic [MagW-1:0]        tap_mag;
    logic signed [AccW-1:0] addend;

    always_comb begin
        shamt   = emax_q - exp_q[cnt_q];
        tap_mag = (shamt >= ExpInW'(AccW)) ? '0 : sm_q[cnt_q][MagW-1:0] >> shamt;
        addend  = $signed({{(AccW - MagW){1'b0}}, tap_mag});
        if (sm_q[cnt_q][MagW]) addend = -addend;
    end

    logic [AccW-1:0] acc_abs;
    logic [PosW-1:0] lead_pos;
    logic            acc_zero;

    assign acc_abs = acc_q[AccW-1] ? -acc_q : acc_q;

    lead_one_detector #(
        .Width(AccW),
        .PosW (PosW)
    ) u_lod (
        .data(acc_abs),
        .pos (lead_pos),
        .zero(acc_zero)
    );

    // Normalisation is split: first cycle aligns the leading one to the MSB, second packs.
    logic [AccW-1:0]        norm_mag_q;
    logic signed [ExpW-1:0] norm_exp_q;
    logic                   norm_sign_q, norm_zero_q;

    logic [MANT_SIZE-1:0]   mant, mant_rnd;
    logic                   guard, sticky, round_up, carry;
    logic signed [ExpW-1:0] exp_rnd;

    assign mant   = norm_mag_q[AccW-2 -: MANT_SIZE];
    assign guard  = norm_mag_q[AccW-2-MANT_SIZE];
    assign sticky = |norm_mag_q[AccW-3-MANT_SIZE:0];

`ifdef CONV_ACC_ROUND_NEAREST_EN
    assign round_up = guard & (sticky | mant[0]);
`else
    logic unused_rnd;
    assign unused_rnd = guard ^ sticky;
    assign round_up   = 1'b0;
`endif

    always_comb begin
        {carry, mant_rnd} = {1'b0, mant} + (MANT_SIZE + 1)'(round_up);
        exp_rnd           = norm_exp_q + $signed(ExpW'(carry));
        if (norm_zero_q || exp_rnd[ExpW-1] || exp_rnd == '0) begin
            result_d = '0;
        end else if (exp_rnd >= $signed(ExpW'(ExpMax))) begin
            result_d = {norm_sign_q, EXP_SIZE'(SatExp), MANT_SIZE'(SatMant)};
        end else begin
            result_d = {norm_sign_q, exp_rnd[EXP_SIZE-1:0], mant_rnd};
        end
    end

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        phase_d   = phase_q;
        load      = 1'b0;
        norm_load = 1'b0;
        res_load  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    load    = 1'b1;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = StAcc;
                end
            end
            StAcc: begin
                acc_d = acc_q + addend;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CntW'(Taps - 1)) begin
                    phase_d = 1'b0;
                    state_d = StNorm;
                end
            end
            StNorm: begin
                if (!phase_q) begin
                    norm_load = 1'b1;
                    phase_d   = 1'b1;
                end else begin
                    res_load = 1'b1;
                    phase_d  = 1'b0;
                    state_d  = StOut;
                end
            end
            StOut: begin
                if (out_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            acc_q    <= '0;
            cnt_q    <= '0;
            phase_q  <= 1'b0;
            result_q <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
            if (res_load) result_q <= result_d;
        end
    end

    always_ff @(posedge clk) begin
        if (load) begin
            sm_q   <= in_sm;
            exp_q  <= in_exp;
            emax_q <= emax_in;
        end
        if (norm_load) begin
            norm_mag_q  <= acc_abs << (PosW'(AccW - 1) - lead_pos);
            norm_exp_q  <= $signed(ExpW'(emax_q)) + $signed(ExpW'(lead_pos))
                           - $signed(ExpW'(BinPt));
            norm_sign_q <= acc_q[AccW-1];
            norm_zero_q <= acc_zero;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StOut);
    assign result    = result_q;

endmodule
